// File: rtl/aes_sbox_scheduler_pkg.sv
// Shared AES definitions for the S-box scheduler and other AES blocks.
// Contents:
//   AES_BLOCK_W / AES_WORD_W : 128-bit state width, 32-bit key word width
//   sched_state_e            : scheduler FSM encoding (IDLE / RUN / DONE)
//   aes_sbox()               : FIPS-197 forward S-box lookup, byte in -> byte out
package aes_sbox_scheduler_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Forward S-box, entry n is the substitution of byte value n.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_scheduler_if.sv
// Request/response bundle between the S-box scheduler and its two requesters.
// Signals:
//   st_valid/st_ready/st_in         : 128-bit state request handshake
//   st_out_valid/st_out_ready/st_out: substituted state, held until taken
//   kw_valid/kw_ready/kw_in         : 32-bit key-word request handshake
//   kw_out_valid/kw_out             : one-cycle result pulse, word held after
// Modports: master = requester side, slave = scheduler side.
interface aes_sbox_scheduler_if;
  import aes_sbox_scheduler_pkg::*;

  logic                   st_valid;
  logic                   st_ready;
  logic [AES_BLOCK_W-1:0] st_in;
  logic                   st_out_valid;
  logic                   st_out_ready;
  logic [AES_BLOCK_W-1:0] st_out;
  logic                   kw_valid;
  logic                   kw_ready;
  logic [AES_WORD_W-1:0]  kw_in;
  logic                   kw_out_valid;
  logic [AES_WORD_W-1:0]  kw_out;

  modport master (
    output st_valid, st_in, st_out_ready, kw_valid, kw_in,
    input  st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out
  );

  modport slave (
    input  st_valid, st_in, st_out_ready, kw_valid, kw_in,
    output st_ready, st_out_valid, st_out, kw_ready, kw_out_valid, kw_out
  );

endinterface

// File: rtl/aes_sbox_scheduler_lane.sv
// One combinational S-box lane.
// Ports:
//   din  in  8 : byte to substitute
//   dout out 8 : substituted byte
module aes_sbox_scheduler_lane
  import aes_sbox_scheduler_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = aes_sbox(din);

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Shares one bank of LANES S-box lanes between full-state SubBytes (processed
// iteratively, LANES bytes per cycle) and 32-bit key-expansion SubWord.
// Ports:
//   clk   in  1 : rising-edge clock
//   rst_n in  1 : synchronous reset, active low
//   bus   slave : state and key-word request/response handshakes
//   busy  out 1 : FSM not in IDLE
// Parameters:
//   LANES    : bytes substituted per cycle, 4 / 8 / 16
//   KEY_PRIO : 0 = round-robin under contention, 1 = key word always wins
module aes_sbox_scheduler
  import aes_sbox_scheduler_pkg::*;
#(
  parameter int LANES    = 4,
  parameter bit KEY_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_sbox_scheduler_if.slave  bus,
  output logic                 busy
);

  localparam int LANE_W = 8 * LANES;
  localparam int CHUNKS = AES_BLOCK_W / LANE_W;

  if (!(LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sbox_scheduler: LANES must be 4, 8 or 16");
  end

  sched_state_e           state_q, state_d;
  logic                   rr_q;
  logic [AES_BLOCK_W-1:0] data_q, data_sub;
  logic [LANE_W-1:0]      chunk_in, chunk_out, lane_in;
  logic [AES_WORD_W-1:0]  kw_out_q;
  logic                   kw_out_valid_q;
  logic                   key_grant, key_fire, st_accept, st_advance, last_chunk;

  // Next state and handshakes. In RUN the state always wants the lanes, so a
  // valid key word is always a contention; rr_q low means the key is favoured.
  always_comb begin
    state_d          = state_q;
    bus.st_ready     = 1'b0;
    bus.st_out_valid = 1'b0;
    bus.kw_ready     = 1'b1;
    key_grant        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.st_ready = 1'b1;
        if (bus.st_valid) state_d = RUN;
      end
      RUN: begin
        key_grant    = bus.kw_valid && (KEY_PRIO || !rr_q);
        bus.kw_ready = key_grant;
        if (!key_grant && last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.st_out_valid = 1'b1;
        if (bus.st_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign key_fire   = bus.kw_valid && bus.kw_ready;
  assign st_accept  = (state_q == IDLE) && bus.st_valid;
  assign st_advance = (state_q == RUN) && !key_grant;

  // A key grant borrows the low four lanes; the rest keep seeing the chunk.
  always_comb begin
    lane_in = chunk_in;
    if (key_fire) lane_in[AES_WORD_W-1:0] = bus.kw_in;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_scheduler_lane u_lane (
      .din  (lane_in[8*i +: 8]),
      .dout (chunk_out[8*i +: 8])
    );
  end

  // With 16 lanes the whole state goes through in one cycle and no chunk
  // counter exists; otherwise cnt_q walks the chunks in ascending byte order.
  if (CHUNKS == 1) begin : g_single
    assign chunk_in   = data_q;
    assign data_sub   = chunk_out;
    assign last_chunk = 1'b1;
  end else begin : g_multi
    localparam int CNT_W = $clog2(CHUNKS);
    logic [CNT_W-1:0] cnt_q;

    assign chunk_in   = data_q[cnt_q*LANE_W +: LANE_W];
    assign last_chunk = (cnt_q == CNT_W'(CHUNKS - 1));

    always_comb begin
      data_sub = data_q;
      data_sub[cnt_q*LANE_W +: LANE_W] = chunk_out;
    end

    always_ff @(posedge clk) begin
      if (!rst_n)          cnt_q <= '0;
      else if (st_accept)  cnt_q <= '0;
      else if (st_advance) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Reset drops any partial state, so an interrupted SubBytes never surfaces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q         <= '0;
      rr_q           <= 1'b0;
      kw_out_q       <= '0;
      kw_out_valid_q <= 1'b0;
    end else begin
      kw_out_valid_q <= key_fire;
      if (key_fire) kw_out_q <= chunk_out[AES_WORD_W-1:0];
      if (st_accept)       data_q <= bus.st_in;
      else if (st_advance) data_q <= data_sub;
      if (state_q == RUN && bus.kw_valid) rr_q <= ~rr_q;
    end
  end

  assign bus.st_out       = data_q;
  assign bus.kw_out       = kw_out_q;
  assign bus.kw_out_valid = kw_out_valid_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Self-checking bench for aes_sbox_scheduler (LANES=4, KEY_PRIO=0).
// Expected results come from an independent GF(2^8) S-box model or from the
// FIPS-197 reference vectors, queued at request time and popped on output.
module tb_aes_sbox_scheduler;

  logic clk;
  logic rst_n;
  logic busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] st_exp [$];
  logic [31:0]  kw_exp [$];
  logic [31:0]  mon_exp;

  localparam logic [127:0] VEC_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VEC_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

  aes_sbox_scheduler_if bus ();

  aes_sbox_scheduler #(.LANES(4), .KEY_PRIO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00)
      for (int k = 1; k < 256; k++)
        if (gmul(b, 8'(k)) == 8'h01) inv = 8'(k);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_model(w[8*j +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox_model(s[8*j +: 8]);
    return r;
  endfunction

  // Advance to the next falling edge, drive the key request and queue the
  // expected word if the scheduler accepts it at the coming rising edge.
  task automatic tick(input logic kv, input logic [31:0] kin);
    @(negedge clk);
    bus.kw_valid = kv;
    bus.kw_in    = kin;
    #1;
    if (kv && bus.kw_ready === 1'b1) kw_exp.push_back(model_word(kin));
  endtask

  // Key results are checked wherever they appear.
  always @(negedge clk) begin
    if (bus.kw_out_valid === 1'b1) begin
      total++;
      if (kw_exp.size() == 0) begin
        bad++;
        $display("[TB] FAIL kw_unexpected: kw_out=%h with nothing pending", bus.kw_out);
      end else begin
        mon_exp = kw_exp.pop_front();
        if (bus.kw_out !== mon_exp) begin
          bad++;
          $display("[TB] FAIL kw_result: got %h want %h", bus.kw_out, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    total++; if (bus.st_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_st_out_valid: got %b want 0", bus.st_out_valid); end
    total++; if (bus.kw_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_kw_out_valid: got %b want 0", bus.kw_out_valid); end
    total++; if (bus.st_out !== 128'h0) begin bad++; $display("[TB] FAIL reset_st_out: got %h want 0", bus.st_out); end
    total++; if (bus.kw_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_kw_out: got %h want 0", bus.kw_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(1'b0, 32'h0);
    total++; if (bus.st_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_st_ready: got %b want 1", bus.st_ready); end
  endtask

  task automatic test_state();
    int lat;
    tick(1'b0, 32'h0);
    total++; if (bus.st_ready !== 1'b1) begin bad++; $display("[TB] FAIL state_ready_idle: got %b want 1", bus.st_ready); end
    bus.st_valid = 1'b1; bus.st_in = VEC_IN; st_exp.push_back(VEC_OUT);
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b0;
    total++; if (busy !== 1'b1 || bus.st_ready !== 1'b0) begin bad++; $display("[TB] FAIL state_run_flags: busy=%b st_ready=%b want 1/0", busy, bus.st_ready); end
    lat = 0;
    while (bus.st_out_valid !== 1'b1 && lat < 20) begin tick(1'b0, 32'h0); lat++; end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL state_latency: got %0d want 4", lat); end
    total++; if (bus.st_out !== st_exp[0]) begin bad++; $display("[TB] FAIL state_result: got %h want %h", bus.st_out, st_exp[0]); end
    void'(st_exp.pop_front());
    tick(1'b0, 32'h0);
    total++; if (bus.st_out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL state_release: valid=%b busy=%b want 0/0", bus.st_out_valid, busy); end
  endtask

  task automatic test_key_idle();
    tick(1'b1, 32'hcf4f3c09);
    total++; if (bus.kw_ready !== 1'b1) begin bad++; $display("[TB] FAIL key_idle_ready: got %b want 1", bus.kw_ready); end
    tick(1'b0, 32'h0);
    total++; if (bus.kw_out_valid !== 1'b1 || bus.kw_out !== 32'h8a84eb01) begin bad++; $display("[TB] FAIL key_idle_result: valid=%b out=%h want 1/8a84eb01", bus.kw_out_valid, bus.kw_out); end
    tick(1'b0, 32'h0);
    total++; if (bus.kw_out_valid !== 1'b0 || bus.kw_out !== 32'h8a84eb01) begin bad++; $display("[TB] FAIL key_idle_hold: valid=%b out=%h want 0/8a84eb01", bus.kw_out_valid, bus.kw_out); end
  endtask

  task automatic test_contention();
    int lat, grants, alt_err;
    logic prev;
    tick(1'b1, $urandom);
    bus.st_valid = 1'b1; bus.st_in = VEC_IN; st_exp.push_back(VEC_OUT);
    tick(1'b1, $urandom);
    bus.st_valid = 1'b0;
    lat = 0; grants = 0; alt_err = 0; prev = 1'b0;
    while (bus.st_out_valid !== 1'b1 && lat < 40) begin
      if (bus.kw_ready === 1'b1) grants++;
      if (lat > 0 && bus.kw_ready === prev) alt_err++;
      prev = bus.kw_ready;
      tick(1'b1, $urandom);
      lat++;
    end
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL contention_latency: got %0d want 8", lat); end
    total++; if (grants !== 4 || alt_err !== 0) begin bad++; $display("[TB] FAIL contention_grants: key=%0d breaks=%0d want 4/0", grants, alt_err); end
    total++; if (bus.st_out !== st_exp[0]) begin bad++; $display("[TB] FAIL contention_result: got %h want %h", bus.st_out, st_exp[0]); end
    void'(st_exp.pop_front());
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    total++; if (bus.st_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL contention_release: got %b want 0", bus.st_out_valid); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    bus.st_out_ready = 1'b0;
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b1; bus.st_in = v; st_exp.push_back(model_state(v));
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b0;
    lat = 0;
    while (bus.st_out_valid !== 1'b1 && lat < 20) begin tick(1'b0, 32'h0); lat++; end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL bp_latency: got %0d want 4", lat); end
    for (int k = 0; k < 5; k++) begin
      tick(k == 2, $urandom);
      if (k == 2) begin
        total++; if (bus.kw_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_key_ready: got %b want 1", bus.kw_ready); end
      end
      total++;
      if (bus.st_out_valid !== 1'b1 || bus.st_ready !== 1'b0 || bus.st_out !== st_exp[0]) begin
        bad++;
        $display("[TB] FAIL bp_hold: valid=%b st_ready=%b out=%h want 1/0/%h", bus.st_out_valid, bus.st_ready, bus.st_out, st_exp[0]);
      end
    end
    bus.st_out_ready = 1'b1;
    void'(st_exp.pop_front());
    tick(1'b0, 32'h0);
    total++; if (bus.st_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: got %b want 0", bus.st_out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [127:0] v;
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b1; bus.st_in = {$urandom, $urandom, $urandom, $urandom};
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b0;
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    rst_n = 1'b0;
    tick(1'b0, 32'h0);
    rst_n = 1'b1;
    total++;
    if (bus.st_out_valid !== 1'b0 || busy !== 1'b0 || bus.st_ready !== 1'b1 || bus.st_out !== 128'h0) begin
      bad++;
      $display("[TB] FAIL midreset_state: valid=%b busy=%b st_ready=%b out=%h want 0/0/1/0", bus.st_out_valid, busy, bus.st_ready, bus.st_out);
    end
    v = {$urandom, $urandom, $urandom, $urandom};
    bus.st_valid = 1'b1; bus.st_in = v; st_exp.push_back(model_state(v));
    tick(1'b0, 32'h0);
    bus.st_valid = 1'b0;
    lat = 0;
    while (bus.st_out_valid !== 1'b1 && lat < 20) begin tick(1'b0, 32'h0); lat++; end
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL midreset_latency: got %0d want 4", lat); end
    total++; if (bus.st_out !== st_exp[0]) begin bad++; $display("[TB] FAIL midreset_result: got %h want %h", bus.st_out, st_exp[0]); end
    void'(st_exp.pop_front());
    tick(1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int lat, grants;
    logic [127:0] v;
    for (int n = 0; n < 3; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      tick(1'b0, 32'h0);
      bus.st_valid = 1'b1; bus.st_in = v; st_exp.push_back(model_state(v));
      tick(1'($urandom_range(0, 1)), $urandom);
      bus.st_valid = 1'b0;
      lat = 0; grants = 0;
      while (bus.st_out_valid !== 1'b1 && lat < 40) begin
        if (bus.kw_valid === 1'b1 && bus.kw_ready === 1'b1) grants++;
        tick(1'($urandom_range(0, 1)), $urandom);
        lat++;
      end
      total++; if (lat !== 4 + grants || lat > 8) begin bad++; $display("[TB] FAIL b2b_latency[%0d]: got %0d want %0d", n, lat, 4 + grants); end
      total++; if (bus.st_out !== st_exp[0]) begin bad++; $display("[TB] FAIL b2b_result[%0d]: got %h want %h", n, bus.st_out, st_exp[0]); end
      void'(st_exp.pop_front());
      tick(1'b0, 32'h0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.st_valid     = 1'b0;
    bus.st_in        = '0;
    bus.st_out_ready = 1'b1;
    bus.kw_valid     = 1'b0;
    bus.kw_in        = '0;

    test_reset();
    test_state();
    test_key_idle();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();

    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    total++; if (kw_exp.size() !== 0) begin bad++; $display("[TB] FAIL kw_pending: got %0d left want 0", kw_exp.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
